// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: opcode and size codes, FSM states,
// the captured request bundle and the access-size helper.
package mem_pkg;
  localparam logic [31:0] MEM_NONE  = 32'd0;
  localparam logic [31:0] MEM_LOAD  = 32'd1;
  localparam logic [31:0] MEM_STORE = 32'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  typedef struct packed {
    logic        write;
    logic [63:0] ex_res;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [4:0]  dst;
    logic [2:0]  size;
    logic        ecall;
  } mem_req_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: picks the addressed bytes out of the aligned doubleword
// and sign- or zero-extends them to 64 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  addr,
  input  logic [2:0]  size,
  output logic [63:0] result
);
  logic [63:0] sh;
  assign sh = rdata >> {addr, 3'b000};

  always_comb begin
    result = sh;
    case (size[1:0])
      SZ_B: result = size[2] ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      SZ_H: result = size[2] ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      SZ_W: result = size[2] ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: result = sh;
    endcase
  end
endmodule

// File: rtl/pipeline_mem.sv
// RV64 memory stage: issues one load/store at a time to the data port and
// presents a registered writeback bundle, stalling execute while busy.
module pipeline_mem
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ex_res,
  input  logic [DATA_WIDTH-1:0] r2_val_mem,
  input  logic [4:0]            mem_dst_reg,
  input  logic [31:0]           next_mem_opcode,
  input  logic [2:0]            next_mem_operation_size,
  input  logic                  ecall_mem,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_write,
  output logic [ADDR_WIDTH-1:0] dmem_req_addr,
  output logic [DATA_WIDTH-1:0] dmem_req_wdata,
  output logic [7:0]            dmem_req_wstrb,
  input  logic                  dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_resp_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic                  wb_en,
  output logic [4:0]            wb_dst_reg,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ecall,
  output logic                  wb_misaligned
);
  state_e      state, state_nx;
  mem_req_t    cap;
  logic        slot_free, accept, is_load, is_store, is_mem, misal;
  logic [2:0]  off;
  logic [3:0]  sb, sbm1;
  logic [8:0]  mask;
  logic [7:0]  st_wstrb;
  logic [63:0] st_wdata, load_res;

  assign off       = ex_res[2:0];
  assign is_load   = (next_mem_opcode == MEM_LOAD);
  assign is_store  = (next_mem_opcode == MEM_STORE);
  assign is_mem    = is_load | is_store;
  assign sb        = size_bytes(next_mem_operation_size[1:0]);
  assign sbm1      = sb - 4'd1;
  assign misal     = |(off & sbm1[2:0]);
  assign mask      = (9'd1 << sb) - 9'd1;
  assign st_wstrb  = mask[7:0] << off;
  assign st_wdata  = r2_val_mem << {off, 3'b000};

  assign slot_free = !wb_valid || wb_ready;
  assign in_ready  = (state == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;

  // Request fields are only presented while a request is pending.
  assign dmem_req_valid = (state == REQ);
  assign dmem_req_write = (state == REQ) && cap.write;
  assign dmem_req_addr  = (state == REQ) ? {cap.ex_res[ADDR_WIDTH-1:3], 3'b000} : '0;
  assign dmem_req_wdata = (state == REQ && cap.write) ? cap.wdata : '0;
  assign dmem_req_wstrb = (state == REQ && cap.write) ? cap.wstrb : '0;

  mem_load_align u_align (
    .rdata  (dmem_resp_rdata),
    .addr   (cap.ex_res[2:0]),
    .size   (cap.size),
    .result (load_res)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_mem && !misal) state_nx = REQ;
      REQ:     if (dmem_req_ready) state_nx = cap.write ? IDLE : WAIT;
      WAIT:    if (dmem_resp_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cap           <= '0;
      wb_valid      <= 1'b0;
      wb_en         <= 1'b0;
      wb_dst_reg    <= '0;
      wb_data       <= '0;
      wb_ecall      <= 1'b0;
      wb_misaligned <= 1'b0;
    end else begin
      state <= state_nx;
      if (wb_valid && wb_ready) wb_valid <= 1'b0;
      if (accept) begin
        if (is_mem && !misal) begin
          cap.write  <= is_store;
          cap.ex_res <= ex_res;
          cap.wdata  <= st_wdata;
          cap.wstrb  <= st_wstrb;
          cap.dst    <= mem_dst_reg;
          cap.size   <= next_mem_operation_size;
          cap.ecall  <= ecall_mem;
        end else begin
          // Non-memory ops and misaligned faults complete immediately.
          wb_valid      <= 1'b1;
          wb_en         <= !is_mem && (mem_dst_reg != 5'd0);
          wb_dst_reg    <= mem_dst_reg;
          wb_data       <= ex_res;
          wb_ecall      <= ecall_mem;
          wb_misaligned <= is_mem;
        end
      end
      if (state == REQ && dmem_req_ready && cap.write) begin
        wb_valid      <= 1'b1;
        wb_en         <= 1'b0;
        wb_dst_reg    <= cap.dst;
        wb_data       <= cap.ex_res;
        wb_ecall      <= cap.ecall;
        wb_misaligned <= 1'b0;
      end
      if (state == WAIT && dmem_resp_valid) begin
        wb_valid      <= 1'b1;
        wb_en         <= (cap.dst != 5'd0);
        wb_dst_reg    <= cap.dst;
        wb_data       <= load_res;
        wb_ecall      <= cap.ecall;
        wb_misaligned <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_mem.sv
// Bench for pipeline_mem: directed literal cases followed by random traffic,
// all checked every cycle against a bundle-level reference model.
module tb_pipeline_mem;
  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [63:0] ex_res, r2_val_mem;
  logic [4:0]  mem_dst_reg;
  logic [31:0] next_mem_opcode;
  logic [2:0]  next_mem_operation_size;
  logic        ecall_mem;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_write;
  logic [63:0] dmem_req_addr, dmem_req_wdata;
  logic [7:0]  dmem_req_wstrb;
  logic        dmem_resp_valid;
  logic [63:0] dmem_resp_rdata;
  logic        wb_valid, wb_ready, wb_en, wb_ecall, wb_misaligned;
  logic [4:0]  wb_dst_reg;
  logic [63:0] wb_data;

  int errors = 0;
  int checks = 0;

  pipeline_mem #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ex_res(ex_res), .r2_val_mem(r2_val_mem), .mem_dst_reg(mem_dst_reg),
    .next_mem_opcode(next_mem_opcode), .next_mem_operation_size(next_mem_operation_size),
    .ecall_mem(ecall_mem), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_write(dmem_req_write), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_en(wb_en), .wb_dst_reg(wb_dst_reg),
    .wb_data(wb_data), .wb_ecall(wb_ecall), .wb_misaligned(wb_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (bundle level) ----------------
  typedef struct {
    bit        en;
    bit [4:0]  dst;
    bit [63:0] data;
    bit        ecall;
    bit        mis;
    bit        st;
  } wb_t;

  typedef struct {
    bit        st;
    bit [63:0] ex;
    bit [63:0] wdata;
    bit [7:0]  wstrb;
    bit [4:0]  dst;
    int        off;
    int        nb;
    bit        zext;
    bit        ecall;
  } op_t;

  bit  m_wbv, m_busy, m_waiting;
  wb_t m_wb;
  op_t m_op;
  wire m_in_ready = !m_busy && (!m_wbv || wb_ready);

  function automatic logic [63:0] ref_load(logic [63:0] rd, int off, int nb, bit zext);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!zext && nb < 8 && v[8*nb-1])
      for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  always @(posedge clk) begin
    bit  rdy, nw;
    wb_t nv;
    rdy = m_in_ready;
    nw  = 1'b0;
    nv  = '{default: 0};
    if (reset) begin
      m_wbv = 0; m_busy = 0; m_waiting = 0;
    end else begin
      if (!m_busy) begin
        if (in_valid && rdy) begin
          int  nb, off;
          bit  mem;
          nb  = 1 << next_mem_operation_size[1:0];
          off = int'(ex_res[2:0]);
          mem = (next_mem_opcode == 1) || (next_mem_opcode == 2);
          if (mem && (off % nb == 0)) begin
            m_busy = 1; m_waiting = 0;
            m_op.st = (next_mem_opcode == 2);
            m_op.ex = ex_res;
            m_op.wdata = r2_val_mem << (8 * off);
            m_op.wstrb = '0;
            for (int i = 0; i < nb; i++) m_op.wstrb[off+i] = 1'b1;
            m_op.dst = mem_dst_reg; m_op.off = off; m_op.nb = nb;
            m_op.zext = next_mem_operation_size[2]; m_op.ecall = ecall_mem;
          end else begin
            nw = 1;
            nv = '{en: !mem && mem_dst_reg != 0, dst: mem_dst_reg, data: ex_res,
                   ecall: ecall_mem, mis: mem, st: 0};
          end
        end
      end else if (!m_waiting) begin
        if (dmem_req_ready) begin
          if (m_op.st) begin
            nw = 1; m_busy = 0;
            nv = '{en: 0, dst: m_op.dst, data: m_op.ex, ecall: m_op.ecall, mis: 0, st: 1};
          end else m_waiting = 1;
        end
      end else if (dmem_resp_valid) begin
        nw = 1; m_busy = 0;
        nv = '{en: m_op.dst != 0, dst: m_op.dst,
               data: ref_load(dmem_resp_rdata, m_op.off, m_op.nb, m_op.zext),
               ecall: m_op.ecall, mis: 0, st: 0};
      end
      if (nw) begin m_wbv = 1; m_wb = nv; end
      else if (m_wbv && wb_ready) m_wbv = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    bit reqv;
    @(negedge clk);
    #1;
    reqv = m_busy && !m_waiting;
    chk("in_ready", in_ready, m_in_ready);
    chk("wb_valid", wb_valid, m_wbv);
    if (m_wbv) begin
      chk("wb_en", wb_en, m_wb.en);
      chk("wb_dst", wb_dst_reg, m_wb.dst);
      chk("wb_ecall", wb_ecall, m_wb.ecall);
      chk("wb_mis", wb_misaligned, m_wb.mis);
      if (!m_wb.st) chk("wb_data", wb_data, m_wb.data);
    end
    chk("req_valid", dmem_req_valid, reqv);
    if (reqv) begin
      chk("req_write", dmem_req_write, m_op.st);
      chk("req_addr", dmem_req_addr, {m_op.ex[63:3], 3'b000});
      chk("req_wstrb", dmem_req_wstrb, m_op.st ? m_op.wstrb : 8'h00);
      if (m_op.st) chk("req_wdata", dmem_req_wdata, m_op.wdata);
    end
  end

  // ---------------- random-phase memory responder ----------------
  bit auto_resp = 0;
  int hs_cnt = 0, served = 0, wait_cnt = 0;

  always @(posedge clk)
    if (!reset && dmem_req_valid && dmem_req_ready && !dmem_req_write) hs_cnt++;

  always begin
    @(negedge clk);
    if (!auto_resp) served = hs_cnt;
    else begin
      dmem_resp_valid = 1'b0;
      if (hs_cnt != served) begin
        if (wait_cnt == 0) begin
          dmem_resp_valid = 1'b1;
          dmem_resp_rdata = {$urandom, $urandom};
          served++;
          wait_cnt = $urandom_range(0, 3);
        end else wait_cnt--;
      end else if ($urandom_range(0, 7) == 0) begin
        dmem_resp_valid = 1'b1;      // stray response, must be ignored
        dmem_resp_rdata = {$urandom, $urandom};
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input bit v, input logic [31:0] op, input logic [2:0] sz,
                        input logic [63:0] ex, input logic [63:0] r2,
                        input logic [4:0] dst, input bit ec);
    in_valid = v; next_mem_opcode = op; next_mem_operation_size = sz;
    ex_res = ex; r2_val_mem = r2; mem_dst_reg = dst; ecall_mem = ec;
  endtask

  task automatic load_test(input logic [63:0] ex, input logic [2:0] sz,
                           input logic [63:0] rd, input logic [63:0] exp);
    @(negedge clk); set_in(1, 1, sz, ex, 0, 7, 0); dmem_req_ready = 1;
    @(negedge clk); in_valid = 0; #2;
    chk("ld_req_valid", dmem_req_valid, 1);
    chk("ld_addr", dmem_req_addr, 64'h1000);
    chk("ld_wstrb", dmem_req_wstrb, 8'h00);
    chk("ld_busy", in_ready, 0);
    @(negedge clk); dmem_resp_valid = 1; dmem_resp_rdata = rd; #2;
    chk("ld_wait_nowb", wb_valid, 0);
    @(negedge clk); dmem_resp_valid = 0; #2;
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, exp);
    chk("ld_wb_en", wb_en, 1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1; wb_ready = 1; dmem_req_ready = 0;
    dmem_resp_valid = 0; dmem_resp_rdata = '0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_req_valid", dmem_req_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_req_addr", dmem_req_addr, 0);
    @(negedge clk); reset = 0;

    // back-to-back non-memory ops
    @(negedge clk); set_in(1, 0, 3, 64'h1234, 0, 5, 0);
    @(negedge clk); set_in(1, 0, 3, 64'h5678, 0, 0, 1); #2;
    chk("none_valid", wb_valid, 1);
    chk("none_en", wb_en, 1);
    chk("none_data", wb_data, 64'h1234);
    @(negedge clk); in_valid = 0; #2;
    chk("none2_valid", wb_valid, 1);
    chk("none2_en_x0", wb_en, 0);
    chk("none2_data", wb_data, 64'h5678);
    chk("none2_ecall", wb_ecall, 1);
    @(negedge clk); #2;
    chk("none_drained", wb_valid, 0);

    load_test(64'h1003, 3'b000, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80);
    load_test(64'h1003, 3'b100, 64'h00000000_80000000, 64'h00000000_00000080);

    // halfword store with the port stalled for three cycles
    @(negedge clk); set_in(1, 2, 1, 64'h1006, 64'hABCD, 9, 0); dmem_req_ready = 0;
    repeat (3) begin
      @(negedge clk); in_valid = 0; #2;
      chk("st_req_valid", dmem_req_valid, 1);
      chk("st_addr", dmem_req_addr, 64'h1000);
      chk("st_wstrb", dmem_req_wstrb, 8'hC0);
      chk("st_wdata", dmem_req_wdata, 64'hABCD0000_00000000);
      chk("st_stall", in_ready, 0);
    end
    @(negedge clk); dmem_req_ready = 1; #2;
    chk("st_req_hold", dmem_req_valid, 1);
    @(negedge clk); dmem_req_ready = 0; #2;
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_en", wb_en, 0);
    chk("st_req_done", dmem_req_valid, 0);

    // misaligned word load
    @(negedge clk); set_in(1, 1, 2, 64'h1002, 0, 4, 0);
    @(negedge clk); in_valid = 0; #2;
    chk("mis_no_req", dmem_req_valid, 0);
    chk("mis_valid", wb_valid, 1);
    chk("mis_flag", wb_misaligned, 1);
    chk("mis_en", wb_en, 0);
    chk("mis_data", wb_data, 64'h1002);

    // writeback backpressure
    @(negedge clk); wb_ready = 0; set_in(1, 0, 3, 64'hAAA, 0, 3, 0);
    repeat (4) begin
      @(negedge clk); set_in(1, 0, 3, 64'hBBB, 0, 6, 0); #2;
      chk("bp_hold_data", wb_data, 64'hAAA);
      chk("bp_hold_dst", wb_dst_reg, 3);
      chk("bp_stall", in_ready, 0);
    end
    @(negedge clk); wb_ready = 1; #2;
    chk("bp_release", in_ready, 1);
    @(negedge clk); in_valid = 0; #2;
    chk("bp_next_data", wb_data, 64'hBBB);
    chk("bp_next_dst", wb_dst_reg, 6);
    @(negedge clk); #2;
    chk("bp_drained", wb_valid, 0);

    // reset while a load waits for its response
    @(negedge clk); set_in(1, 1, 3, 64'h2000, 0, 8, 0); dmem_req_ready = 1;
    @(negedge clk); in_valid = 0;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0; dmem_resp_valid = 1; dmem_resp_rdata = 64'hDEAD_BEEF; #2;
    chk("rw_in_ready", in_ready, 1);
    chk("rw_wb_valid", wb_valid, 0);
    chk("rw_req_valid", dmem_req_valid, 0);
    chk("rw_wb_data", wb_data, 0);
    @(negedge clk); dmem_resp_valid = 0; #2;
    chk("rw_late_resp", wb_valid, 0);

    // random traffic
    @(negedge clk); auto_resp = 1;
    for (int n = 0; n < 3000; n++) begin
      int       k;
      bit [2:0] sz;
      bit [63:0] ex;
      @(negedge clk);
      k  = $urandom_range(0, 7);
      sz = 3'($urandom_range(0, 7));
      ex = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) ex[2:0] = ex[2:0] & ~3'((1 << sz[1:0]) - 1);
      set_in($urandom_range(0, 3) != 0,
             (k < 3) ? 32'd1 : (k < 5) ? 32'd2 : (k == 5) ? 32'd0 : 32'h0001_0003,
             sz, ex, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
             $urandom_range(0, 1) == 1);
      wb_ready       = $urandom_range(0, 3) != 0;
      dmem_req_ready = $urandom_range(0, 1) == 1;
    end
    @(negedge clk); in_valid = 0; wb_ready = 1; dmem_req_ready = 1;
    repeat (20) @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
